// File: rtl/nlc_horner_mc.sv
// Multi-channel polynomial linearizer: FIFO-buffered samples are normalized per
// channel/section and evaluated by a Horner loop, one coefficient per cycle.
module nlc_horner_mc #(
  parameter int NCH    = 2,
  parameter int ORDER  = 10,
  parameter int XW     = 21,
  parameter int CW     = 48,
  parameter int FRAC   = 24,
  parameter int FIFO_D = 4,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW    = $clog2(NCH*4*(ORDER+3))
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          srdyi,
  input  logic [XW-1:0] x_adc,
  input  logic [CHW-1:0] ch_i,
  output logic          drdy_o,
  output logic          srdyo,
  output logic [XW-1:0] x_lin,
  output logic [CHW-1:0] ch_o,
  input  logic [XW-1:0] section_limit,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [CW-1:0] cfg_wdata,
  output logic          cfg_rdy_o,
  output logic          ovf_o
);

  localparam int DEPTH = NCH*4*(ORDER+3);
  localparam int PW    = 2*CW + 2;
  localparam int KW    = $clog2(ORDER+1);
  localparam int FPW   = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int FCW   = $clog2(FIFO_D+1);
  localparam int IW    = AW + 3;

  localparam logic signed [PW-1:0] CMAX = {{(PW-CW+1){1'b0}}, {(CW-1){1'b1}}};
  localparam logic signed [PW-1:0] CMIN = {{(PW-CW+1){1'b1}}, {(CW-1){1'b0}}};
  localparam logic signed [CW-1:0] XMAX = {{(CW-XW+1){1'b0}}, {(XW-1){1'b1}}};
  localparam logic signed [CW-1:0] XMIN = {{(CW-XW+1){1'b1}}, {(XW-1){1'b0}}};

  typedef struct packed {
    logic [CHW-1:0]       ch;
    logic signed [XW-1:0] x;
  } smp_t;

  typedef enum logic [2:0] {IDLE, SEL, NORM, HORN, OUT} state_t;

  function automatic logic signed [CW-1:0] sat_cw(input logic signed [PW-1:0] v);
    if (v > CMAX)      return CMAX[CW-1:0];
    else if (v < CMIN) return CMIN[CW-1:0];
    else               return v[CW-1:0];
  endfunction

  logic signed [CW-1:0] cfg_mem [DEPTH];
  smp_t                 fifo_mem [FIFO_D];
  logic [FPW-1:0]       wptr, rptr;
  logic [FCW-1:0]       count;
  logic                 push, pop, last;
  state_t               state, state_d;

  smp_t                 cur;
  logic [1:0]           sec, sec_d;
  logic [KW-1:0]        kcnt;
  logic signed [CW-1:0] t, acc, t_d, acc_h, c_k, nm, rs, ysh;
  logic signed [XW:0]   xe, absx;
  logic signed [CW:0]   xw, nsum;
  logic [IW-1:0]        base, a_c, a_nm, a_rs;
  logic                 gt, posx;
  logic [XW-1:0]        y_d;

  assign drdy_o    = count < FCW'(FIFO_D);
  assign cfg_rdy_o = (state == IDLE) && (count == '0);
  assign push      = srdyi && drdy_o;
  assign srdyo     = (state == OUT);
  assign last      = (state == HORN) && (kcnt == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      IDLE, OUT: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = SEL;
        end else begin
          state_d = IDLE;
        end
      end
      SEL:     state_d = NORM;
      NORM:    state_d = HORN;
      HORN:    if (kcnt == '0) state_d = OUT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf_o <= 1'b0;
    end else begin
      if (push) wptr <= (wptr == FPW'(FIFO_D-1)) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == FPW'(FIFO_D-1)) ? '0 : rptr + 1'b1;
      count <= count + FCW'(push) - FCW'(pop);
      if (srdyi && !drdy_o) ovf_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= '{ch: ch_i, x: x_adc};
  end

  // Coefficient store survives reset so a restart needs no reconfiguration.
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_rdy_o && ({1'b0, cfg_addr} < (AW+1)'(DEPTH)))
      cfg_mem[cfg_addr] <= cfg_wdata;
  end

  always_comb begin
    // |x| needs one extra bit so the most negative sample stays positive.
    xe    = {cur.x[XW-1], cur.x};
    absx  = xe[XW] ? -xe : xe;
    gt    = absx > $signed({1'b0, section_limit});
    posx  = !xe[XW] && (xe != '0);
    sec_d = posx ? (gt ? 2'd3 : 2'd2) : (gt ? 2'd0 : 2'd1);

    base = IW'({cur.ch, sec}) * IW'(ORDER + 3);
    a_nm = base + IW'(ORDER + 1);
    a_rs = base + IW'(ORDER + 2);
    a_c  = base + ((state == NORM) ? IW'(ORDER) : IW'(kcnt));
    c_k  = (a_c  < IW'(DEPTH)) ? cfg_mem[a_c[AW-1:0]]  : '0;
    nm   = (a_nm < IW'(DEPTH)) ? cfg_mem[a_nm[AW-1:0]] : '0;
    rs   = (a_rs < IW'(DEPTH)) ? cfg_mem[a_rs[AW-1:0]] : '0;

    xw    = {{(CW+1-XW){cur.x[XW-1]}}, cur.x};
    nsum  = (xw <<< FRAC) + (CW+1)'(nm);
    t_d   = sat_cw((PW'(nsum) * PW'(rs)) >>> FRAC);
    acc_h = sat_cw(((PW'(acc) * PW'(t)) >>> FRAC) + PW'(c_k));

    ysh = acc_h >>> FRAC;
    if (ysh > XMAX)      y_d = XMAX[XW-1:0];
    else if (ysh < XMIN) y_d = XMIN[XW-1:0];
    else                 y_d = ysh[XW-1:0];
  end

  always_ff @(posedge clk) begin
    if (pop) cur <= fifo_mem[rptr];
    case (state)
      SEL:  sec <= sec_d;
      NORM: begin
        t    <= t_d;
        acc  <= c_k;
        kcnt <= KW'(ORDER - 1);
      end
      HORN: begin
        acc  <= acc_h;
        kcnt <= kcnt - 1'b1;
      end
      default: ;
    endcase
  end

  // Result registers are loaded from the final Horner step and hold until the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_lin <= '0;
      ch_o  <= '0;
    end else if (last) begin
      x_lin <= y_d;
      ch_o  <= cur.ch;
    end
  end

endmodule

// File: tb/tb_nlc_horner_mc.sv
// Bench for nlc_horner_mc: table vectors, hand-written corner sequences and
// random samples against a wide-integer reference polynomial model.
module tb_nlc_horner_mc;
  localparam int NCH = 2, ORDER = 10, XW = 21, CW = 48, FRAC = 24, FIFO_D = 4;
  localparam int CHW = 1;
  localparam int AW  = $clog2(NCH*4*(ORDER+3));
  localparam int NK  = ORDER + 3;
  localparam logic signed [CW-1:0] ONE = CW'(1) << FRAC;

  typedef logic signed [127:0] wide_t;
  typedef struct {logic signed [XW-1:0] x; logic [CHW-1:0] ch; int cyc;} res_t;
  typedef struct {int ch; int x; int ex;} vec_t;

  logic clk = 1'b0;
  logic reset, srdyi, drdy_o, srdyo, cfg_we, cfg_rdy_o, ovf_o;
  logic [XW-1:0]  x_adc, x_lin, section_limit;
  logic [CHW-1:0] ch_i, ch_o;
  logic [AW-1:0]  cfg_addr;
  logic [CW-1:0]  cfg_wdata;

  int checks = 0, errors = 0, cyc = 0;
  logic signed [CW-1:0] shadow [NCH][4][NK];
  res_t obs[$], exq[$];
  vec_t sec_tv[7];

  nlc_horner_mc dut (
    .clk(clk), .reset(reset), .srdyi(srdyi), .x_adc(x_adc), .ch_i(ch_i),
    .drdy_o(drdy_o), .srdyo(srdyo), .x_lin(x_lin), .ch_o(ch_o),
    .section_limit(section_limit), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdy_o(cfg_rdy_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (srdyo === 1'b1) obs.push_back('{x_lin, ch_o, cyc});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(string nm, logic signed [63:0] got, logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic wide_t satw(wide_t v, int w);
    wide_t mx, mn;
    mx = (wide_t'(1) <<< (w - 1)) - 1;
    mn = -(wide_t'(1) <<< (w - 1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  // Reference: pick section from sign and magnitude, normalize, evaluate polynomial.
  function automatic res_t model(int ch, int x);
    wide_t ax, lim, t, acc, y;
    int s;
    lim = '0;
    lim[XW-1:0] = section_limit;
    ax = (x < 0) ? -wide_t'(x) : wide_t'(x);
    if (x > 0) s = (ax > lim) ? 3 : 2;
    else       s = (ax > lim) ? 0 : 1;
    t = satw((((wide_t'(x) <<< FRAC) + wide_t'(shadow[ch][s][NK-2]))
              * wide_t'(shadow[ch][s][NK-1])) >>> FRAC, CW);
    acc = wide_t'(shadow[ch][s][ORDER]);
    for (int k = ORDER - 1; k >= 0; k--)
      acc = satw(((acc * t) >>> FRAC) + wide_t'(shadow[ch][s][k]), CW);
    y = satw(acc >>> FRAC, XW);
    return '{XW'(y), CHW'(ch), 0};
  endfunction

  task automatic cfg_wr(int ch, int s, int k, logic signed [CW-1:0] v);
    int n = 0;
    while (cfg_rdy_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("cfg_rdy_timeout", 0, 1);
    cfg_we    = 1'b1;
    cfg_addr  = AW'((ch*4 + s)*NK + k);
    cfg_wdata = v;
    @(negedge clk);
    cfg_we = 1'b0;
    shadow[ch][s][k] = v;
  endtask

  task automatic set_ch(int ch, logic signed [CW-1:0] c1, logic signed [CW-1:0] c0);
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < NK; k++)
        cfg_wr(ch, s, k, (k == 0) ? c0 : (k == 1) ? c1 : (k == NK-1) ? ONE : '0);
  endtask

  task automatic send(int ch, int x);
    ch_i  = CHW'(ch);
    x_adc = XW'(x);
    srdyi = 1'b1;
    @(negedge clk);
    srdyi = 1'b0;
  endtask

  task automatic drain(string nm, int budget);
    int n = 0;
    while (obs.size() < exq.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (obs.size() < exq.size()) chk({nm, "_timeout"}, obs.size(), exq.size());
    repeat (3) @(negedge clk);
    chk({nm, "_count"}, obs.size(), exq.size());
    for (int i = 0; i < exq.size() && i < obs.size(); i++) begin
      chk({nm, "_x"}, obs[i].x, exq[i].x);
      chk({nm, "_ch"}, obs[i].ch, exq[i].ch);
    end
    obs.delete();
    exq.delete();
  endtask

  task automatic run_one(string nm, int ch, int x, int ex, int ech, bit lat);
    int c0, n;
    obs.delete();
    exq.delete();
    exq.push_back('{XW'(ex), CHW'(ech), 0});
    send(ch, x);
    c0 = cyc;
    n = 0;
    while (obs.size() == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (lat && obs.size() > 0) chk({nm, "_latency"}, obs[0].cyc - c0, ORDER + 3);
    drain(nm, 40);
  endtask

  initial begin
    sec_tv[0] = '{0,  101,  2};
    sec_tv[1] = '{0,  100,  1};
    sec_tv[2] = '{0,    0, -1};
    sec_tv[3] = '{0, -101, -2};
    sec_tv[4] = '{0,    1,  1};
    sec_tv[5] = '{0, -100, -1};
    sec_tv[6] = '{0, -1048576, -2};

    reset = 1'b1; srdyi = 1'b0; x_adc = '0; ch_i = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; section_limit = XW'(100);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_srdyo", srdyo, 0);
    chk("rst_x_lin", x_lin, 0);
    chk("rst_ch_o", ch_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_drdy", drdy_o, 1);
    chk("rst_cfg_rdy", cfg_rdy_o, 1);

    set_ch(0, ONE, '0);
    set_ch(1, 2*ONE, '0);
    run_one("identity", 0, 1000, 1000, 0, 1);
    run_one("identity_neg", 0, -1000, -1000, 0, 1);

    exq.push_back('{XW'(7), 1'b0, 0});
    exq.push_back('{XW'(14), 1'b1, 0});
    exq.push_back('{XW'(7), 1'b0, 0});
    send(0, 7); send(1, 7); send(0, 7);
    drain("multich", 3*NK + 20);

    for (int s = 0; s < 4; s++)
      for (int k = 0; k < NK; k++)
        cfg_wr(0, s, k, (k == 0) ? ((s == 0) ? -2*ONE : (s == 1) ? -ONE : (s == 2) ? ONE : 2*ONE)
                        : (k == NK-1) ? ONE : '0);
    foreach (sec_tv[i])
      run_one($sformatf("section_%0d", i), sec_tv[i].ch, sec_tv[i].x, sec_tv[i].ex, 0, 0);

    // A write attempted while busy must be dropped.
    exq.push_back('{XW'(2), 1'b0, 0});
    send(0, 101);
    repeat (2) @(negedge clk);
    chk("cfg_rdy_busy", cfg_rdy_o, 0);
    cfg_we = 1'b1; cfg_addr = AW'(3*NK); cfg_wdata = 99*ONE;
    @(negedge clk);
    cfg_we = 1'b0;
    drain("busy_write", 40);
    run_one("busy_write_kept", 0, 101, 2, 0, 0);

    set_ch(0, ONE, 10*ONE);
    run_one("sat_pos", 0, 1048575, 1048575, 0, 0);
    set_ch(0, ONE, -10*ONE);
    run_one("sat_neg", 0, -1048576, -1048576, 0, 0);

    set_ch(0, ONE, '0);
    srdyi = 1'b1;
    ch_i  = '0;
    for (int i = 0; i < 6; i++) begin
      x_adc = XW'(11 + i);
      @(negedge clk);
      if (i == 4) chk("drdy_full", drdy_o, 0);
    end
    srdyi = 1'b0;
    chk("ovf_set", ovf_o, 1);
    for (int i = 0; i < 5; i++) exq.push_back('{XW'(11 + i), 1'b0, 0});
    drain("overflow", 5*NK + 20);
    chk("ovf_sticky", ovf_o, 1);

    obs.delete();
    send(0, 500);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_pulse", obs.size(), 0);
    chk("midrst_ovf", ovf_o, 0);
    chk("midrst_cfg_rdy", cfg_rdy_o, 1);
    chk("midrst_x_lin", x_lin, 0);
    run_one("after_reset", 0, 321, 321, 0, 1);

    section_limit = XW'($urandom_range(0, 300));
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < 4; s++)
        for (int k = 0; k < NK; k++) begin
          int r;
          if (k == NK-1)      r = int'($urandom_range(0, 131072)) - 65536;
          else if (k == NK-2) r = int'($urandom_range(0, 536870911)) - 268435456;
          else                r = int'($urandom_range(0, 67108863)) - 33554432;
          cfg_wr(c, s, k, CW'(r));
        end
    for (int b = 0; b < 12; b++) begin
      int len;
      len = int'($urandom_range(1, 4));
      for (int j = 0; j < len; j++) begin
        int ch, x, mode;
        ch   = int'($urandom_range(0, NCH - 1));
        mode = int'($urandom_range(0, 7));
        x    = (mode == 0) ? -1048576 : (mode == 1) ? 1048575 : int'($urandom_range(0, 600)) - 300;
        exq.push_back(model(ch, x));
        send(ch, x);
      end
      drain("random", 4*NK + 20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
